dbus_arbiter: RTL

- Shares the single data-memory port (RAM plus memory-mapped GPIO) between two requesters.
- Master 0 is the core load/store path. Master 1 is a loader/DMA engine that fills RAM and inspects it.
- Fixed priority goes to master 0. A starvation counter forces a grant to master 1 after a bounded wait.
- Read data from the memory returns one cycle after the accepted request and is steered back to the master that issued it.

---
 rtl/dbus_arbiter_if.sv | 59 +++++
 rtl/dbus_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/dbus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dbus_arbiter_if
// Description : Two-master data-bus bundle plus shared memory port.
// Revision    : 1.0 - initial release
// ============================================================================
interface dbus_arbiter_if #(
   parameter int MXLEN = 32
);
   logic             m0_req;
   logic             m0_we;
   logic [MXLEN-1:0] m0_addr;
   logic [MXLEN-1:0] m0_wdata;
   logic [3:0]       m0_wstrb;
   logic             m0_gnt;
   logic             m0_rvalid;
   logic [MXLEN-1:0] m0_rdata;

   logic             m1_req;
   logic             m1_we;
   logic [MXLEN-1:0] m1_addr;
   logic [MXLEN-1:0] m1_wdata;
   logic [3:0]       m1_wstrb;
   logic             m1_gnt;
   logic             m1_rvalid;
   logic [MXLEN-1:0] m1_rdata;

   logic             mem_en;
   logic             mem_we;
   logic [MXLEN-1:0] mem_addr;
   logic [MXLEN-1:0] mem_wdata;
   logic [3:0]       mem_wstrb;
   logic [MXLEN-1:0] mem_rdata;

   logic             starved;

   // Arbiter side
   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_rdata,
      output starved
   );

   // Requester / memory side
   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_rdata,
      input  starved
   );
endinterface
`default_nettype wire

// File: rtl/dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dbus_arbiter
// Description : Fixed-priority data-port arbiter with master-1 starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_arbiter #(
   parameter int MXLEN      = 32,
   parameter int STARVE_MAX = 4
) (
   input logic           CLK,
   input logic           RST,
   dbus_arbiter_if.slave bus
);
   localparam logic [0:0]       c_ST_NORMAL  = 1'b0;
   localparam logic [0:0]       c_ST_FORCE1  = 1'b1;
   localparam logic [1:0]       c_OWN_NONE   = 2'd0;
   localparam logic [1:0]       c_OWN_M0     = 2'd1;
   localparam logic [1:0]       c_OWN_M1     = 2'd2;
   localparam logic [3:0]       c_STARVE_MAX = 4'(STARVE_MAX);
   localparam logic [MXLEN-1:0] c_ZERO       = '0;

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [3:0]       r_cnt;
   logic [3:0]       w_cnt_nxt;
   logic [1:0]       r_owner;
   logic [1:0]       w_owner_nxt;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_rv0;
   logic             w_rv1;
   logic             w_mem_we;
   logic [MXLEN-1:0] w_mem_addr;
   logic [MXLEN-1:0] w_mem_wdata;
   logic [3:0]       w_mem_wstrb;

   // Grants are purely combinational; reset blocks every acceptance.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!RST) begin
         if (r_state == c_ST_FORCE1) begin
            w_gnt1 = bus.m1_req;
            w_gnt0 = bus.m0_req && !bus.m1_req;
         end else begin
            w_gnt0 = bus.m0_req;
            w_gnt1 = bus.m1_req && !bus.m0_req;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (r_state == c_ST_FORCE1) begin
         // Either the forced grant happened or master 1 withdrew.
         if (w_gnt1 || !bus.m1_req) begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = c_ST_NORMAL;
         end
      end else if (w_gnt1) begin
         w_cnt_nxt = 4'd0;
      end else if (bus.m1_req) begin
         if (r_cnt < c_STARVE_MAX) begin
            w_cnt_nxt = r_cnt + 4'd1;
         end
         if (w_cnt_nxt == c_STARVE_MAX) begin
            w_state_nxt = c_ST_FORCE1;
         end
      end
   end

   always_comb begin
      w_owner_nxt = c_OWN_NONE;
      if (w_gnt0 && !bus.m0_we) begin
         w_owner_nxt = c_OWN_M0;
      end else if (w_gnt1 && !bus.m1_we) begin
         w_owner_nxt = c_OWN_M1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= c_ST_NORMAL;
         r_cnt   <= 4'd0;
         r_owner <= c_OWN_NONE;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = c_ZERO;
      w_mem_wdata = c_ZERO;
      w_mem_wstrb = 4'd0;
      if (w_gnt0) begin
         w_mem_we    = bus.m0_we;
         w_mem_addr  = bus.m0_addr;
         w_mem_wdata = bus.m0_wdata;
         w_mem_wstrb = bus.m0_wstrb;
      end else if (w_gnt1) begin
         w_mem_we    = bus.m1_we;
         w_mem_addr  = bus.m1_addr;
         w_mem_wdata = bus.m1_wdata;
         w_mem_wstrb = bus.m1_wstrb;
      end
   end

   // A read owner registered just before reset must not surface during it.
   assign w_rv0 = (r_owner == c_OWN_M0) && !RST;
   assign w_rv1 = (r_owner == c_OWN_M1) && !RST;

   assign bus.m0_gnt    = w_gnt0;
   assign bus.m1_gnt    = w_gnt1;
   assign bus.m0_rvalid = w_rv0;
   assign bus.m1_rvalid = w_rv1;
   assign bus.m0_rdata  = w_rv0 ? bus.mem_rdata : c_ZERO;
   assign bus.m1_rdata  = w_rv1 ? bus.mem_rdata : c_ZERO;
   assign bus.mem_en    = w_gnt0 || w_gnt1;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;
   assign bus.mem_wstrb = w_mem_wstrb;
   assign bus.starved   = (r_state == c_ST_FORCE1) && !RST;

endmodule
`default_nettype wire
